// File: rtl/serial_multrom_rom_arbiter_if.sv
// serial_multrom_rom_arbiter_if: requester-side and ROM-side signals of the shared multiply-ROM arbiter
interface serial_multrom_rom_arbiter_if #(
  parameter int HALF_WIDTH = 2,
  parameter int NUM_REQ    = 4
);
  localparam int AW = 2 * HALF_WIDTH;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ-1:0]    gnt;
  logic [AW-1:0]         rom_address;
  logic [AW-1:0]         rom_dout;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [AW-1:0]         rsp_data;
  logic                  busy;
  modport master (
    output req, req_addr, rom_dout,
    input  gnt, rom_address, rsp_valid, rsp_data, busy
  );
  modport slave (
    input  req, req_addr, rom_dout,
    output gnt, rom_address, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/serial_multrom_rom_arbiter.sv
// serial_multrom_rom_arbiter: round-robin sharing of one multiply ROM, 2-cycle pipelined lookups (SERIAL_MULTROM_ARB_FIXED_PRIO_EN selects fixed priority)
module serial_multrom_rom_arbiter #(
  parameter int HALF_WIDTH = 2,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2
) (
  input logic clk,
  input logic rst_n,
  serial_multrom_rom_arbiter_if.slave bus
);
  localparam int AW = 2 * HALF_WIDTH;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    gnt_id;
  logic [ID_W-1:0]    idx;
  logic [ID_W:0]      sum;
  logic               found;
  logic               s1_valid;
  logic [ID_W-1:0]    s1_id;
  logic [NUM_REQ-1:0] gnt_v;
`ifdef SERIAL_MULTROM_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [ID_W-1:0] nxt_ptr;
  assign nxt_ptr = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
  // priority pointer moves just past the requester that was served
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (found) ptr <= nxt_ptr;
`endif
  // search from ptr with wraparound; first asserted request wins
  always_comb begin
    gnt_v  = '0;
    gnt_id = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (ID_W+1)'(k);
      idx = (sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum - (ID_W+1)'(NUM_REQ)) : ID_W'(sum);
      if (!found && bus.req[idx]) begin
        found       = 1'b1;
        gnt_v[idx]  = 1'b1;
        gnt_id      = idx;
      end
    end
  end
  assign bus.gnt  = gnt_v;
  assign bus.busy = s1_valid | (|bus.rsp_valid);
  // stage 1 registers the granted address, stage 2 registers the ROM result
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.rom_address <= '0;
      s1_valid        <= 1'b0;
      s1_id           <= '0;
      bus.rsp_valid   <= '0;
      bus.rsp_data    <= '0;
    end else begin
      if (found) begin
        bus.rom_address <= bus.req_addr[gnt_id*AW +: AW];
        s1_id           <= gnt_id;
      end
      s1_valid      <= found;
      bus.rsp_valid <= s1_valid ? NUM_REQ'(1) << s1_id : '0;
      if (s1_valid) bus.rsp_data <= bus.rom_dout;
    end
endmodule

// File: tb/tb_serial_multrom_rom_arbiter.sv
// tb_serial_multrom_rom_arbiter: directed checks of arbitration, pipeline, reset and idle behaviour
module tb_serial_multrom_rom_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int errs = 0;
  serial_multrom_rom_arbiter_if #(.HALF_WIDTH(2), .NUM_REQ(4)) bus ();
  serial_multrom_rom_arbiter #(.HALF_WIDTH(2), .NUM_REQ(4), .ID_W(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  assign bus.rom_dout = {2'b00, bus.rom_address[3:2]} * {2'b00, bus.rom_address[1:0]};
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  logic [3:0] g_all [5];
  logic [3:0] d_all [5];
  logic [3:0] g_wrap [3];
  logic [3:0] b2b_a [3];
  logic [3:0] b2b_d [3];
  initial begin
`ifdef SERIAL_MULTROM_ARB_FIXED_PRIO_EN
    g_all  = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    d_all  = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
    g_wrap = '{4'b0001, 4'b0001, 4'b0001};
`else
    g_all  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    d_all  = '{4'd1, 4'd2, 4'd3, 4'd9, 4'd1};
    g_wrap = '{4'b0001, 4'b1000, 4'b0001};
`endif
    b2b_a = '{4'hF, 4'hE, 4'hD};
    b2b_d = '{4'd9, 4'd6, 4'd3};
    bus.req = '0;
    bus.req_addr = '0;
    tick();
    tick();
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_rom_address", 32'(bus.rom_address), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    rst_n = 1'b1;
    tick();
    // single request from requester 0
    bus.req = 4'b0001;
    bus.req_addr[3:0] = 4'hB;
    #1 chk("single_gnt", 32'(bus.gnt), 32'h1);
    tick();
    bus.req = '0;
    chk("single_rom_address", 32'(bus.rom_address), 32'hB);
    chk("single_busy", 32'(bus.busy), 1);
    chk("single_rsp_early", 32'(bus.rsp_valid), 0);
    tick();
    chk("single_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("single_rsp_data", 32'(bus.rsp_data), 6);
    tick();
    chk("single_rsp_pulse", 32'(bus.rsp_valid), 0);
    chk("single_data_hold", 32'(bus.rsp_data), 6);
    chk("single_busy_end", 32'(bus.busy), 0);
    // restart from ptr=0 for the all-request rotation
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    bus.req_addr = {4'hF, 4'h7, 4'h6, 4'h5};
    for (int k = 0; k < 7; k++) begin
      bus.req = (k < 5) ? 4'b1111 : 4'b0000;
      #1 chk("all_gnt", 32'(bus.gnt), (k < 5) ? 32'(g_all[k]) : 0);
      if (k >= 2) begin
        chk("all_rsp_valid", 32'(bus.rsp_valid), 32'(g_all[k-2]));
        chk("all_rsp_data", 32'(bus.rsp_data), 32'(d_all[k-2]));
      end
      tick();
    end
    // wrap: serve requester 3, then req=1001
    bus.req = 4'b1000;
    #1 chk("wrap_gnt3", 32'(bus.gnt), 32'h8);
    tick();
    for (int k = 0; k < 3; k++) begin
      bus.req = 4'b1001;
      #1 chk("wrap_gnt", 32'(bus.gnt), 32'(g_wrap[k]));
      tick();
    end
    bus.req = '0;
    tick();
    tick();
    tick();
    // back-to-back lookups by requester 1
    for (int k = 0; k < 5; k++) begin
      bus.req = (k < 3) ? 4'b0010 : 4'b0000;
      if (k < 3) bus.req_addr[7:4] = b2b_a[k];
      #1;
      if (k < 3) chk("b2b_gnt", 32'(bus.gnt), 32'h2);
      if (k >= 2) begin
        chk("b2b_rsp_valid", 32'(bus.rsp_valid), 32'h2);
        chk("b2b_rsp_data", 32'(bus.rsp_data), 32'(b2b_d[k-2]));
      end
      tick();
    end
    chk("b2b_rsp_end", 32'(bus.rsp_valid), 0);
    // reset one cycle after a grant discards the lookup
    bus.req = 4'b0001;
    bus.req_addr[3:0] = 4'hA;
    tick();
    bus.req = '0;
    rst_n = 1'b0;
    #1;
    chk("midrst_rom_address", 32'(bus.rom_address), 0);
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("midrst_rsp_data", 32'(bus.rsp_data), 0);
    chk("midrst_busy", 32'(bus.busy), 0);
    tick();
    chk("midrst_rsp_valid2", 32'(bus.rsp_valid), 0);
    rst_n = 1'b1;
    tick();
    chk("midrst_rsp_valid3", 32'(bus.rsp_valid), 0);
    tick();
    chk("midrst_rsp_valid4", 32'(bus.rsp_valid), 0);
    bus.req = 4'b0101;
    #1 chk("midrst_ptr0", 32'(bus.gnt), 32'h1);
    bus.req = 4'b0100;
    #1 chk("midrst_gnt", 32'(bus.gnt), 32'h4);
    tick();
    bus.req = '0;
    tick();
    chk("midrst_rsp_valid5", 32'(bus.rsp_valid), 32'h4);
    chk("midrst_rsp_data5", 32'(bus.rsp_data), 3);
    tick();
    // idle
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("idle_gnt", 32'(bus.gnt), 0);
      chk("idle_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("idle_busy", 32'(bus.busy), 0);
      chk("idle_rom_address", 32'(bus.rom_address), 32'h7);
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
